boot_loader: RTL and testbench

- Parametrised program/data loader between the boot ROM, the main memory and the CPU's IM and DM.
- After reset, on system_enable it walks a descriptor list in ROM. Each descriptor copies a burst of words from main memory into IM or DM at one word per cycle.
- It holds the CPU in reset until the list terminates. It replaces the fixed single-image load with multi-segment loading, DM targets, error reporting and a copy counter.

---
 rtl/boot_loader.sv | 159 +++++++++++++++
 tb/tb_boot_loader.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// Boot loader: walks a descriptor list in ROM and copies bursts of main-memory
// words into IM or DM, holding the CPU in reset until the list terminates.
module boot_loader #(
    parameter int DATA_W = 32,
    parameter int ROM_AW = 8,
    parameter int MEM_AW = 14,
    parameter int IM_AW  = 10,
    parameter int DM_AW  = 15,
    parameter int DST_W  = 14,
    parameter int LEN_W  = 6,
    parameter int CNT_W  = 16,
    parameter int DESC_W = 2 + LEN_W + MEM_AW + DST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              system_enable,
    output logic              rom_enable,
    output logic              rom_read,
    output logic [ROM_AW-1:0] rom_address,
    input  logic [DESC_W-1:0] rom_out,
    output logic              MEM_en,
    output logic              MEM_read,
    output logic              MEM_write,
    output logic [MEM_AW-1:0] MEM_addr,
    input  logic [DATA_W-1:0] MEM_data,
    output logic              IM_enable,
    output logic              IM_write,
    output logic [IM_AW-1:0]  IM_address,
    output logic [DATA_W-1:0] IM_in,
    output logic              DM_enable,
    output logic              DM_write,
    output logic [DM_AW-1:0]  DM_address,
    output logic [DATA_W-1:0] DM_in,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  words_copied
);

    localparam int OP_LSB  = DESC_W - 2;
    localparam int LEN_LSB = OP_LSB - LEN_W;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_COPY, S_DONE, S_ERR
    } state_t;

    state_t             state, state_nx;
    logic [ROM_AW-1:0]  ptr;
    logic [1:0]         op_r;
    logic [LEN_W-1:0]   len_r;
    logic [MEM_AW-1:0]  src_r;
    logic [DST_W-1:0]   dst_r;
    logic [LEN_W:0]     k;
    logic [LEN_W:0]     k_m1;
    logic [LEN_W:0]     n_words;
    logic [CNT_W-1:0]   cnt;

    assign n_words      = {1'b0, len_r} + {{LEN_W{1'b0}}, 1'b1};
    assign k_m1         = k - {{LEN_W{1'b0}}, 1'b1};
    assign MEM_write    = 1'b0;
    assign words_copied = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            ptr   <= '0;
            op_r  <= '0;
            len_r <= '0;
            src_r <= '0;
            dst_r <= '0;
            k     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_DECODE: begin
                    op_r  <= rom_out[DESC_W-1 -: 2];
                    len_r <= rom_out[OP_LSB-1 -: LEN_W];
                    src_r <= rom_out[LEN_LSB-1 -: MEM_AW];
                    dst_r <= rom_out[DST_W-1:0];
                    k     <= '0;
                end
                S_COPY: begin
                    k <= k + {{LEN_W{1'b0}}, 1'b1};
                    if (k != '0 && cnt != '1) cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (k == n_words && ptr != '1) ptr <= ptr + {{(ROM_AW-1){1'b0}}, 1'b1};
                end
                default: ;
            endcase
        end
    end

    // Memories return read data the cycle after the read strobe, so COPY reads
    // word k while writing word k-1 and needs one extra drain cycle.
    always_comb begin
        state_nx    = state;
        rom_enable  = 1'b0;
        rom_read    = 1'b0;
        rom_address = '0;
        MEM_en      = 1'b0;
        MEM_read    = 1'b0;
        MEM_addr    = '0;
        IM_enable   = 1'b0;
        IM_write    = 1'b0;
        IM_address  = '0;
        IM_in       = '0;
        DM_enable   = 1'b0;
        DM_write    = 1'b0;
        DM_address  = '0;
        DM_in       = '0;
        cpu_hold    = 1'b1;
        done        = 1'b0;
        error       = 1'b0;
        case (state)
            S_IDLE: if (system_enable) state_nx = S_FETCH;
            S_FETCH: begin
                rom_enable  = 1'b1;
                rom_read    = 1'b1;
                rom_address = ptr;
                state_nx    = S_DECODE;
            end
            S_DECODE: begin
                case (rom_out[DESC_W-1 -: 2])
                    2'b00:   state_nx = S_DONE;
                    2'b11:   state_nx = S_ERR;
                    default: state_nx = S_COPY;
                endcase
            end
            S_COPY: begin
                if (k != n_words) begin
                    MEM_en   = 1'b1;
                    MEM_read = 1'b1;
                    MEM_addr = src_r + MEM_AW'(k);
                end
                if (k != '0) begin
                    if (op_r == 2'b01) begin
                        IM_enable  = 1'b1;
                        IM_write   = 1'b1;
                        IM_address = IM_AW'(dst_r) + IM_AW'(k_m1);
                        IM_in      = MEM_data;
                    end else begin
                        DM_enable  = 1'b1;
                        DM_write   = 1'b1;
                        DM_address = DM_AW'(dst_r) + DM_AW'(k_m1);
                        DM_in      = MEM_data;
                    end
                end
                if (k == n_words) state_nx = (ptr == '1) ? S_ERR : S_FETCH;
            end
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            S_ERR: error = 1'b1;
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: memory models around the DUT, a descriptor-walking
// reference model producing the expected per-cycle outputs, and image checks.
module tb_boot_loader;

    localparam int DESC_W = 36;
    localparam int TERM_REPS = 4;

    typedef struct packed {
        logic        rom_en;
        logic        rom_rd;
        logic [7:0]  rom_addr;
        logic        mem_en;
        logic        mem_rd;
        logic        mem_wr;
        logic [13:0] mem_addr;
        logic        im_en;
        logic        im_wr;
        logic [9:0]  im_addr;
        logic [31:0] im_data;
        logic        dm_en;
        logic        dm_wr;
        logic [14:0] dm_addr;
        logic [31:0] dm_data;
        logic        hold;
        logic        dn;
        logic        err;
        logic [15:0] words;
    } obs_t;

    localparam int OBS_W = $bits(obs_t);

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic system_enable = 1'b0;
    always #5 clk = ~clk;

    logic              rom_enable, rom_read;
    logic [7:0]        rom_address;
    logic [DESC_W-1:0] rom_out = '0;
    logic              MEM_en, MEM_read, MEM_write;
    logic [13:0]       MEM_addr;
    logic [31:0]       MEM_data = '0;
    logic              IM_enable, IM_write;
    logic [9:0]        IM_address;
    logic [31:0]       IM_in;
    logic              DM_enable, DM_write;
    logic [14:0]       DM_address;
    logic [31:0]       DM_in;
    logic              cpu_hold, done, error;
    logic [15:0]       words_copied;

    boot_loader dut (
        .clk(clk), .rst(rst), .system_enable(system_enable),
        .rom_enable(rom_enable), .rom_read(rom_read), .rom_address(rom_address),
        .rom_out(rom_out),
        .MEM_en(MEM_en), .MEM_read(MEM_read), .MEM_write(MEM_write),
        .MEM_addr(MEM_addr), .MEM_data(MEM_data),
        .IM_enable(IM_enable), .IM_write(IM_write), .IM_address(IM_address), .IM_in(IM_in),
        .DM_enable(DM_enable), .DM_write(DM_write), .DM_address(DM_address), .DM_in(DM_in),
        .cpu_hold(cpu_hold), .done(done), .error(error), .words_copied(words_copied)
    );

    // memory models
    logic [DESC_W-1:0] rom    [0:255];
    logic [31:0]       mem    [0:16383];
    logic [31:0]       im_mem [0:1023];
    logic [31:0]       dm_mem [0:32767];

    always @(posedge clk) begin
        if (rom_enable && rom_read) rom_out <= rom[rom_address];
        if (MEM_en && MEM_read) MEM_data <= mem[MEM_addr];
        if (IM_enable && IM_write) im_mem[IM_address] <= IM_in;
        if (DM_enable && DM_write) dm_mem[DM_address] <= DM_in;
    end

    // scoreboard state
    logic [OBS_W-1:0] exp_q[$];
    logic [31:0]      exp_im [int];
    logic [31:0]      exp_dm [int];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc_idx = 0;
    int first_done_cyc = -1;
    int first_err_cyc = -1;
    obs_t exp_rec, act_rec;

    function automatic obs_t snap_dut();
        obs_t r;
        r.rom_en = rom_enable;  r.rom_rd = rom_read;   r.rom_addr = rom_address;
        r.mem_en = MEM_en;      r.mem_rd = MEM_read;   r.mem_wr = MEM_write;
        r.mem_addr = MEM_addr;
        r.im_en = IM_enable;    r.im_wr = IM_write;    r.im_addr = IM_address; r.im_data = IM_in;
        r.dm_en = DM_enable;    r.dm_wr = DM_write;    r.dm_addr = DM_address; r.dm_data = DM_in;
        r.hold = cpu_hold;      r.dn = done;           r.err = error;
        r.words = words_copied;
        return r;
    endfunction

    function automatic obs_t idle_rec(input int w);
        obs_t r;
        r = '0;
        r.hold = 1'b1;
        r.words = w[15:0];
        return r;
    endfunction

    function automatic logic [DESC_W-1:0] desc(input int op, input int len, input int src, input int dst);
        return {op[1:0], len[5:0], src[13:0], dst[13:0]};
    endfunction

    // reference model: expected output of every cycle from the first FETCH on
    task automatic build_model();
        int ptr, words, len, src, dst, n, a, ta;
        logic [1:0] op;
        logic [31:0] d;
        bit fin;
        obs_t r;
        exp_q.delete();
        exp_im.delete();
        exp_dm.delete();
        cyc_idx = 0;
        first_done_cyc = -1;
        first_err_cyc = -1;
        ptr = 0;
        words = 0;
        fin = 0;
        while (!fin) begin
            r = idle_rec(words);
            r.rom_en = 1'b1;
            r.rom_rd = 1'b1;
            r.rom_addr = ptr[7:0];
            exp_q.push_back(r);
            exp_q.push_back(idle_rec(words));
            op  = rom[ptr][35:34];
            len = int'(rom[ptr][33:28]);
            src = int'(rom[ptr][27:14]);
            dst = int'(rom[ptr][13:0]);
            if (op == 2'b00) begin
                r = '0;
                r.dn = 1'b1;
                r.words = words[15:0];
                repeat (TERM_REPS) exp_q.push_back(r);
                fin = 1;
            end else if (op == 2'b11) begin
                r = idle_rec(words);
                r.err = 1'b1;
                repeat (TERM_REPS) exp_q.push_back(r);
                fin = 1;
            end else begin
                n = len + 1;
                for (int k = 0; k <= n; k++) begin
                    r = idle_rec(words);
                    if (k < n) begin
                        r.mem_en = 1'b1;
                        r.mem_rd = 1'b1;
                        a = (src + k) % 16384;
                        r.mem_addr = a[13:0];
                    end
                    if (k >= 1) begin
                        a = (src + k - 1) % 16384;
                        d = mem[a];
                        if (op == 2'b01) begin
                            ta = (dst % 1024 + k - 1) % 1024;
                            r.im_en = 1'b1; r.im_wr = 1'b1; r.im_addr = ta[9:0]; r.im_data = d;
                            exp_im[ta] = d;
                        end else begin
                            ta = (dst + k - 1) % 32768;
                            r.dm_en = 1'b1; r.dm_wr = 1'b1; r.dm_addr = ta[14:0]; r.dm_data = d;
                            exp_dm[ta] = d;
                        end
                    end
                    exp_q.push_back(r);
                    if (k >= 1 && words < 65535) words++;
                end
                if (ptr == 255) begin
                    r = idle_rec(words);
                    r.err = 1'b1;
                    repeat (TERM_REPS) exp_q.push_back(r);
                    fin = 1;
                end else begin
                    ptr++;
                end
            end
        end
    endtask

    // compare process: one expected record per cycle while a load is checked
    always @(negedge clk) begin
        if (!rst && exp_q.size() > 0) begin
            exp_rec = exp_q.pop_front();
            act_rec = snap_dut();
            n_cmp++;
            if (act_rec !== exp_rec) begin
                n_bad++;
                $display("FAIL cycle_%0d: got %h expected %h", cyc_idx + 1, act_rec, exp_rec);
            end
            if (first_done_cyc < 0 && done === 1'b1) first_done_cyc = cyc_idx + 1;
            if (first_err_cyc < 0 && error === 1'b1) first_err_cyc = cyc_idx + 1;
            cyc_idx++;
        end
    end

    // driver / checker tasks
    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic check_obs(input string name, input obs_t act, input obs_t req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        exp_q.delete();
        rst = 1'b1;
        system_enable = 1'b0;
        #1;
        check_obs("reset_outputs", snap_dut(), idle_rec(0));
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic wait_load(input int budget, input bit drop_enable);
        int cnt;
        @(negedge clk);
        #2;
        if (drop_enable) system_enable = 1'b0;
        cnt = 0;
        while (exp_q.size() > 0 && cnt < budget) begin
            @(negedge clk);
            #2;
            cnt++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL load_timeout: got %0d records left expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_load(input int budget, input bit drop_enable);
        @(negedge clk);
        #2;
        build_model();
        system_enable = 1'b1;
        wait_load(budget, drop_enable);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = '0;
    endtask

    task automatic check_images(input string tag);
        foreach (exp_im[a]) check_val($sformatf("%s_im_%0h", tag, a), im_mem[a], exp_im[a]);
        foreach (exp_dm[a]) check_val($sformatf("%s_dm_%0h", tag, a), dm_mem[a], exp_dm[a]);
    endtask

    // stimulus
    initial begin
        int nd, op, len;
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        clear_rom();

        // single IM segment, END
        rom[0] = desc(1, 3, 16'h0010, 16'h0080);
        mem[16] = 32'hAAAA_0001; mem[17] = 32'hBBBB_0002;
        mem[18] = 32'hCCCC_0003; mem[19] = 32'hDDDD_0004;
        do_reset();
        run_load(200, 1'b0);
        check_val("t1_done_cycle", first_done_cyc, 10);
        check_val("t1_words", words_copied, 4);
        check_val("t1_im80", im_mem[128], 32'hAAAA_0001);
        check_val("t1_im81", im_mem[129], 32'hBBBB_0002);
        check_val("t1_im82", im_mem[130], 32'hCCCC_0003);
        check_val("t1_im83", im_mem[131], 32'hDDDD_0004);
        check_val("t1_hold", cpu_hold, 0);

        // END only
        clear_rom();
        do_reset();
        run_load(100, 1'b1);
        check_val("t2_done_cycle", first_done_cyc, 3);
        check_val("t2_words", words_copied, 0);

        // IM segment then DM segment
        rom[0] = desc(1, 1, 100, 200);
        rom[1] = desc(2, 0, 5, 7);
        mem[100] = 32'h1111_0064; mem[101] = 32'h2222_0065; mem[5] = 32'h5555_0005;
        do_reset();
        run_load(200, 1'b0);
        check_val("t3_im200", im_mem[200], 32'h1111_0064);
        check_val("t3_im201", im_mem[201], 32'h2222_0065);
        check_val("t3_dm7", dm_mem[7], 32'h5555_0005);
        check_val("t3_words", words_copied, 3);

        // source and destination wrap
        clear_rom();
        rom[0] = desc(1, 3, 16'h3FFE, 16'h03FE);
        mem[16'h3FFE] = 32'hE000_3FFE; mem[16'h3FFF] = 32'hE000_3FFF;
        mem[0] = 32'hE000_0000; mem[1] = 32'hE000_0001;
        do_reset();
        run_load(200, 1'b1);
        check_val("t4_im3fe", im_mem[10'h3FE], 32'hE000_3FFE);
        check_val("t4_im3ff", im_mem[10'h3FF], 32'hE000_3FFF);
        check_val("t4_im000", im_mem[0], 32'hE000_0000);
        check_val("t4_im001", im_mem[1], 32'hE000_0001);

        // reserved opcode
        rom[0] = desc(3, 2, 3, 4);
        do_reset();
        run_load(100, 1'b1);
        check_val("t5_err_cycle", first_err_cyc, 3);
        check_val("t5_error", error, 1);
        check_val("t5_done", done, 0);
        check_val("t5_hold", cpu_hold, 1);

        // reset during the second COPY cycle, then rerun with enable held
        clear_rom();
        rom[0] = desc(1, 3, 16'h0010, 16'h0080);
        do_reset();
        @(negedge clk);
        #2;
        build_model();
        system_enable = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2;
        check_val("t6_write_active", IM_write, 1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check_obs("t6_reset_mid_copy", snap_dut(), idle_rec(0));
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        build_model();
        wait_load(200, 1'b0);
        check_val("t6_done", done, 1);
        check_val("t6_words", words_copied, 4);
        check_val("t6_im83", im_mem[131], 32'hDDDD_0004);

        // descriptor pointer runs off the end of ROM
        for (int i = 0; i < 256; i++) rom[i] = desc((i % 2) + 1, 0, i * 3, i);
        do_reset();
        run_load(2000, 1'b1);
        check_val("t7_error", error, 1);
        check_val("t7_words", words_copied, 256);
        check_images("t7");

        // random descriptor lists
        for (int t = 0; t < 8; t++) begin
            clear_rom();
            nd = $urandom_range(1, 5);
            for (int d = 0; d < nd; d++) begin
                op  = $urandom_range(1, 2);
                len = ($urandom_range(0, 7) == 0) ? 63 : $urandom_range(0, 20);
                rom[d] = desc(op, len, $urandom_range(0, 16383), $urandom_range(0, 16383));
            end
            if ($urandom_range(0, 4) == 0) rom[nd] = desc(3, 0, 0, 0);
            do_reset();
            run_load(2000, 1'(($urandom_range(0, 1))));
            check_images($sformatf("rand%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
